// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared definitions for the cached-top stack controller.
//   - op_e      : cmd_op encodings (101-111 are NOPs and deliberately unnamed)
//   - state_e   : controller FSM states
//   - DEPTH_EXTRA / depth_width(): depth counter is ADDR_W+2 bits wide so it
//     can count the two cached registers on top of 2^ADDR_W RAM words.
package stack_ctrl_pkg;

  localparam int unsigned DEPTH_EXTRA = 2;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'b000,
    OP_POP     = 3'b001,
    OP_DUP     = 3'b010,
    OP_SWAP    = 3'b011,
    OP_POPREPL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPILL,
    ST_FILL_WAIT,
    ST_FILL_CAP
  } state_e;

  function automatic int unsigned depth_width(input int unsigned addr_w);
    return addr_w + DEPTH_EXTRA;
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: hardware stack with the top two elements cached in registers
// (tos/nos) and deeper elements spilled to an external single-port RAM with a
// 1-cycle registered read.
//
// Ports:
//   CLK, resetn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_data       opcode (PUSH/POP/DUP/SWAP/POPREPL/NOP) and operand
//   tos, nos               cached top / next-of-stack
//   depth, empty, full     element count and status flags
//   err, err_clr           sticky bounds error and its clear
//   ram_addr/ram_wdata/ram_wen/ram_rdata   spill RAM port
//
// Optional feature: define STACK_CTRL_BOUNDS_CHECK_EN to reject out-of-bounds
// commands and report them on err. Without it err/full read 0, every command
// executes, the spill pointer wraps and depth saturates.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic [DATA_W-1:0]             tos,
  output logic [DATA_W-1:0]             nos,
  output logic [ADDR_W+DEPTH_EXTRA-1:0] depth,
  output logic                          empty,
  output logic                          full,
  output logic                          err,
  input  logic                          err_clr,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_wen,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int unsigned         DEPTH_W   = depth_width(ADDR_W);
  localparam logic [DEPTH_W-1:0]  DEPTH_MAX = DEPTH_W'((1 << ADDR_W) + 2);
  localparam logic [DEPTH_W-1:0]  D_TWO     = DEPTH_W'(2);

`ifdef STACK_CTRL_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tos_q, tos_d;
  logic [DATA_W-1:0]   nos_q, nos_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_set;

  logic at_empty, at_full, below_two, ge_two, gt_two;

  assign at_empty  = (depth_q == '0);
  assign at_full   = (depth_q == DEPTH_MAX);
  assign below_two = (depth_q < D_TWO);
  assign ge_two    = !below_two;
  assign gt_two    = (depth_q > D_TWO);

  always_comb begin
    state_d = state_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH, OP_DUP: begin
              if (BOUNDS && (at_full || (cmd_op == OP_DUP && at_empty))) begin
                err_set = 1'b1;
              end else begin
                tos_d = (cmd_op == OP_DUP) ? tos_q : cmd_data;
                nos_d = tos_q;
                if (!at_full) depth_d = depth_q + 1'b1;
                // Old nos drops out of the register cache into RAM; sp
                // advances now since it is not observable until IDLE.
                if (ge_two) begin
                  addr_d  = sp_q;
                  wdata_d = nos_q;
                  sp_d    = sp_q + 1'b1;
                  state_d = ST_SPILL;
                end
              end
            end
            OP_POP, OP_POPREPL: begin
              if (BOUNDS && ((cmd_op == OP_POP) ? at_empty : below_two)) begin
                err_set = 1'b1;
              end else begin
                tos_d = (cmd_op == OP_POP) ? nos_q : cmd_data;
                if (!at_empty) depth_d = depth_q - 1'b1;
                if (gt_two) begin
                  addr_d  = sp_q - 1'b1;
                  sp_d    = sp_q - 1'b1;
                  state_d = ST_FILL_WAIT;
                end else begin
                  nos_d = '0;
                end
              end
            end
            OP_SWAP: begin
              if (BOUNDS && below_two) begin
                err_set = 1'b1;
              end else begin
                tos_d = nos_q;
                nos_d = tos_q;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SPILL:     state_d = ST_IDLE;
      ST_FILL_WAIT: state_d = ST_FILL_CAP;
      ST_FILL_CAP: begin
        nos_d   = ram_rdata;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      sp_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef STACK_CTRL_BOUNDS_CHECK_EN
  logic err_q;

  // Set has priority over clear.
  always_ff @(posedge CLK) begin
    if (!resetn)      err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign err  = err_q;
  assign full = at_full;
`else
  logic unused_nobounds;
  assign unused_nobounds = err_clr ^ err_set;
  assign err  = 1'b0;
  assign full = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign tos       = tos_q;
  assign nos       = nos_q;
  assign depth     = depth_q;
  assign empty     = at_empty;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  // Gated by resetn so a reset landing in SPILL drops the pending write.
  assign ram_wen   = (state_q == ST_SPILL) && resetn;

endmodule
